// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the RV32I instruction encoder.
// Holds the op_kind codes, 7-bit opcode/funct constants (shared with the
// control unit), error codes, the canonical NOP word, and the two pure
// helper functions used by the encoder core: request checking and encoding.
package enc_pkg;

   typedef enum logic [4:0] {
      OP_LUI  = 5'd0,
      OP_BEQ  = 5'd1,
      OP_LW   = 5'd2,
      OP_SW   = 5'd3,
      OP_ADDI = 5'd4,
      OP_SLLI = 5'd5,
      OP_XORI = 5'd6,
      OP_SRLI = 5'd7,
      OP_SRAI = 5'd8,
      OP_ORI  = 5'd9,
      OP_ANDI = 5'd10,
      OP_ADD  = 5'd11,
      OP_SUB  = 5'd12,
      OP_SLL  = 5'd13,
      OP_XOR  = 5'd14,
      OP_SRL  = 5'd15,
      OP_OR   = 5'd16,
      OP_AND  = 5'd17
   } op_kind_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] ERR_NONE        = 2'd0;
   localparam logic [1:0] ERR_UNKNOWN_OP  = 2'd1;
   localparam logic [1:0] ERR_IMM_RANGE   = 2'd2;
   localparam logic [1:0] ERR_BR_MISALIGN = 2'd3;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // Returns the reason a request cannot be encoded, or ERR_NONE.
   // A branch that is both out of range and odd reports the range error.
   function automatic logic [1:0] check_request(input logic [4:0]  op,
                                                input logic [31:0] imm);
      logic signed [31:0] s;
      s = $signed(imm);
      check_request = ERR_NONE;
      case (op)
         OP_LUI: begin
            if (imm[11:0] != 12'd0) check_request = ERR_IMM_RANGE;
         end
         OP_BEQ: begin
            if (s < -32'sd4096 || s > 32'sd4094) check_request = ERR_IMM_RANGE;
            else if (imm[0]) check_request = ERR_BR_MISALIGN;
         end
         OP_LW, OP_SW, OP_ADDI, OP_XORI, OP_ORI, OP_ANDI: begin
            if (s < -32'sd2048 || s > 32'sd2047) check_request = ERR_IMM_RANGE;
         end
         OP_SLLI, OP_SRLI, OP_SRAI: begin
            if (s < 32'sd0 || s > 32'sd31) check_request = ERR_IMM_RANGE;
         end
         OP_ADD, OP_SUB, OP_SLL, OP_XOR, OP_SRL, OP_OR, OP_AND: begin
            check_request = ERR_NONE;
         end
         default: check_request = ERR_UNKNOWN_OP;
      endcase
   endfunction

   // Builds the RV32I machine word; fields an instruction does not use are 0.
   function automatic logic [31:0] encode_word(input logic [4:0]  op,
                                               input logic [4:0]  rd,
                                               input logic [4:0]  rs1,
                                               input logic [4:0]  rs2,
                                               input logic [31:0] imm);
      case (op)
         OP_LUI:  encode_word = {imm[31:12], rd, OPC_LUI};
         OP_BEQ:  encode_word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                                 imm[4:1], imm[11], OPC_BRANCH};
         OP_LW:   encode_word = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
         OP_SW:   encode_word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
         OP_ADDI: encode_word = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
         OP_XORI: encode_word = {imm[11:0], rs1, F3_XOR, rd, OPC_OP_IMM};
         OP_ORI:  encode_word = {imm[11:0], rs1, F3_OR,  rd, OPC_OP_IMM};
         OP_ANDI: encode_word = {imm[11:0], rs1, F3_AND, rd, OPC_OP_IMM};
         OP_SLLI: encode_word = {F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_OP_IMM};
         OP_SRLI: encode_word = {F7_BASE, imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM};
         OP_SRAI: encode_word = {F7_ALT,  imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM};
         OP_ADD:  encode_word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
         OP_SUB:  encode_word = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPC_OP};
         OP_SLL:  encode_word = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_OP};
         OP_XOR:  encode_word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_OP};
         OP_SRL:  encode_word = {F7_BASE, rs2, rs1, F3_SR,  rd, OPC_OP};
         OP_OR:   encode_word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
         OP_AND:  encode_word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
         default: encode_word = 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bus of the instruction encoder.
// Request side : op_valid/op_ready, op_kind, rd, rs1, rs2, imm.
// Output side  : instr_valid/instr_ready, instr, instr_addr.
// Error side   : err_flag, err_code (sticky), err_clr.
// master = program loader / harness, slave = encoder.
interface instr_encoder_if #(parameter int ADDR_W = 10);
   logic              op_valid;
   logic              op_ready;
   logic [4:0]        op_kind;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [31:0]       imm;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_addr;
   logic              err_flag;
   logic [1:0]        err_code;
   logic              err_clr;

   modport master (
      output op_valid, op_kind, rd, rs1, rs2, imm, instr_ready, err_clr,
      input  op_ready, instr_valid, instr, instr_addr, err_flag, err_code
   );

   modport slave (
      input  op_valid, op_kind, rd, rs1, rs2, imm, instr_ready, err_clr,
      output op_ready, instr_valid, instr, instr_addr, err_flag, err_code
   );
endinterface

// File: rtl/enc_fifo2.sv
// enc_fifo2: 2-entry synchronous FIFO with valid/ready on both sides.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data.
// in_ready also accepts when full if the head is popped in the same cycle.
// There is no bypass: a word pushed into an empty FIFO appears next cycle.
module enc_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   assign out_valid = (count_q != 2'd0);
   assign in_ready  = (count_q != 2'd2) || out_ready;
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is qualified by count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I encoder, the inverse of the control decoder.
// Turns a symbolic request (op_kind, rd, rs1, rs2, imm) into a 32-bit machine
// word stamped with an incrementing instruction-memory byte address, queued in
// a 2-entry output FIFO.
// Ports: clk, rst (synchronous, active-high), bus (instr_encoder_if.slave).
// Parameters: ADDR_W (address width), START_ADDR (first address after reset).
// Optional macro INSTR_ENCODER_NOP_ON_ERR_EN: rejected requests push a NOP at
// the next address instead of being dropped, keeping program layout aligned.
module instr_encoder
   import enc_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int START_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst,
   instr_encoder_if.slave      bus
);

   localparam int FIFO_W = 32 + ADDR_W;

   logic [1:0]        req_err;
   logic [31:0]       req_word;
   logic              accept;
   logic              reject;
   logic              push_valid;
   logic [31:0]       push_word;
   logic              fifo_in_ready;
   logic              fifo_out_valid;
   logic [FIFO_W-1:0] fifo_out_data;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_flag_q, err_flag_d;
   logic [1:0]        err_code_q, err_code_d;

   assign req_err   = check_request(bus.op_kind, bus.imm);
   assign req_word  = encode_word(bus.op_kind, bus.rd, bus.rs1, bus.rs2, bus.imm);

   // A rejected request still completes its handshake.
   assign accept    = bus.op_valid && fifo_in_ready;
   assign reject    = accept && (req_err != ERR_NONE);
   assign push_word = (req_err != ERR_NONE) ? NOP_WORD : req_word;

`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
   assign push_valid = accept;
`else
   assign push_valid = accept && !reject;
`endif

   enc_fifo2 #(.WIDTH(FIFO_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (push_valid),
      .in_ready  (fifo_in_ready),
      .in_data   ({push_word, addr_q}),
      .out_valid (fifo_out_valid),
      .out_ready (bus.instr_ready),
      .out_data  (fifo_out_data)
   );

   assign bus.op_ready    = fifo_in_ready;
   assign bus.instr_valid = fifo_out_valid;
   assign bus.instr       = fifo_out_valid ? fifo_out_data[FIFO_W-1 -: 32] : 32'd0;
   assign bus.instr_addr  = fifo_out_valid ? fifo_out_data[ADDR_W-1:0] : addr_q;
   assign bus.err_flag    = err_flag_q;
   assign bus.err_code    = err_code_q;

   // The address advances only on push and wraps naturally at 2^ADDR_W.
   // err_code keeps the first cause; a new error overrides a same-cycle clear.
   always_comb begin
      addr_d     = addr_q;
      err_flag_d = err_flag_q;
      err_code_d = err_code_q;
      if (push_valid) begin
         addr_d = addr_q + ADDR_W'(4);
      end
      if (reject) begin
         err_flag_d = 1'b1;
         if (!err_flag_q || bus.err_clr) begin
            err_code_d = req_err;
         end
      end else if (bus.err_clr) begin
         err_flag_d = 1'b0;
         err_code_d = ERR_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= ADDR_W'(START_ADDR);
         err_flag_q <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         addr_q     <= addr_d;
         err_flag_q <= err_flag_d;
         err_code_q <= err_code_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// Main instance uses ADDR_W=10; a second ADDR_W=4 instance exercises wrap.
// Expectations for rejected requests follow INSTR_ENCODER_NOP_ON_ERR_EN.
module tb_instr_encoder;
   import enc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [9:0] exp_addr;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(10)) bus ();
   instr_encoder_if #(.ADDR_W(4))  w_bus ();

   instr_encoder #(.ADDR_W(10), .START_ADDR(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   instr_encoder #(.ADDR_W(4), .START_ADDR(0)) u_wrap (
      .clk (clk),
      .rst (rst),
      .bus (w_bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [4:0] kind, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im);
      bus.op_valid = 1'b1;
      bus.op_kind  = kind;
      bus.rd       = d;
      bus.rs1      = s1;
      bus.rs2      = s2;
      bus.imm      = im;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.op_valid = 1'b0; bus.op_kind = 5'd0; bus.rd = 5'd0; bus.rs1 = 5'd0;
      bus.rs2 = 5'd0; bus.imm = 32'd0; bus.instr_ready = 1'b0; bus.err_clr = 1'b0;
      w_bus.op_valid = 1'b0; w_bus.op_kind = 5'd0; w_bus.rd = 5'd0; w_bus.rs1 = 5'd0;
      w_bus.rs2 = 5'd0; w_bus.imm = 32'd0; w_bus.instr_ready = 1'b0; w_bus.err_clr = 1'b0;
      step();
      step();
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_ready: got %b expected 1", bus.op_ready); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
      checks++; if (bus.instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", bus.instr); end
      checks++; if (bus.instr_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.instr_addr); end
      checks++; if (bus.err_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_flag: got %b expected 0", bus.err_flag); end
      checks++; if (bus.err_code !== 2'd0) begin errors++; $display("[TB] FAIL reset_err_code: got %0d expected 0", bus.err_code); end
      rst = 1'b0;
   endtask

   task automatic test_addi();
      bus.instr_ready = 1'b1;
      drive_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid: got %b expected 1", bus.instr_valid); end
      checks++; if (bus.instr !== 32'h0050_0093) begin errors++; $display("[TB] FAIL addi_instr: got %h expected 00500093", bus.instr); end
      checks++; if (bus.instr_addr !== 10'd0) begin errors++; $display("[TB] FAIL addi_addr: got %0d expected 0", bus.instr_addr); end
      step();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_drain: got %b expected 0", bus.instr_valid); end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  kinds [4];
      logic [4:0]  rds   [4];
      logic [4:0]  rs1s  [4];
      logic [4:0]  rs2s  [4];
      logic [31:0] imms  [4];
      logic [31:0] words [4];
      logic [9:0]  addrs [4];
      kinds = '{OP_ADD, OP_SUB, OP_LW, OP_SW};
      rds   = '{5'd3, 5'd3, 5'd5, 5'd0};
      rs1s  = '{5'd1, 5'd1, 5'd2, 5'd2};
      rs2s  = '{5'd2, 5'd2, 5'd0, 5'd5};
      imms  = '{32'd0, 32'd0, 32'd8, 32'd12};
      words = '{32'h0020_81B3, 32'h4020_81B3, 32'h0081_2283, 32'h0051_2623};
      addrs = '{10'd4, 10'd8, 10'd12, 10'd16};
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_op(kinds[i], rds[i], rs1s[i], rs2s[i], imms[i]);
         step();
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, bus.instr_valid); end
         checks++; if (bus.instr !== words[i]) begin errors++; $display("[TB] FAIL b2b_instr[%0d]: got %h expected %h", i, bus.instr, words[i]); end
         checks++; if (bus.instr_addr !== addrs[i]) begin errors++; $display("[TB] FAIL b2b_addr[%0d]: got %0d expected %0d", i, bus.instr_addr, addrs[i]); end
      end
      bus.op_valid = 1'b0;
      step();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", bus.instr_valid); end
   endtask

   task automatic test_fifo_full();
      bus.instr_ready = 1'b0;
      drive_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
      step();
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready1: got %b expected 1", bus.op_ready); end
      drive_op(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
      step();
      checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready2: got %b expected 0", bus.op_ready); end
      drive_op(OP_ADDI, 5'd3, 5'd0, 5'd0, 32'd3);
      step();
      checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_ready: got %b expected 0", bus.op_ready); end
      checks++; if (bus.instr !== 32'h0010_0093) begin errors++; $display("[TB] FAIL full_hold_instr: got %h expected 00100093", bus.instr); end
      checks++; if (bus.instr_addr !== 10'd20) begin errors++; $display("[TB] FAIL full_hold_addr: got %0d expected 20", bus.instr_addr); end
      bus.instr_ready = 1'b1;
      #1;
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_ready: got %b expected 1", bus.op_ready); end
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.instr !== 32'h0020_0113) begin errors++; $display("[TB] FAIL full_second_instr: got %h expected 00200113", bus.instr); end
      checks++; if (bus.instr_addr !== 10'd24) begin errors++; $display("[TB] FAIL full_second_addr: got %0d expected 24", bus.instr_addr); end
      step();
      checks++; if (bus.instr !== 32'h0030_0193) begin errors++; $display("[TB] FAIL full_third_instr: got %h expected 00300193", bus.instr); end
      checks++; if (bus.instr_addr !== 10'd28) begin errors++; $display("[TB] FAIL full_third_addr: got %0d expected 28", bus.instr_addr); end
      step();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got %b expected 0", bus.instr_valid); end
   endtask

   task automatic test_encodings();
      logic [4:0]  kinds [3];
      logic [4:0]  rds   [3];
      logic [4:0]  rs1s  [3];
      logic [4:0]  rs2s  [3];
      logic [31:0] imms  [3];
      logic [31:0] words [3];
      logic [9:0]  addrs [3];
      kinds = '{OP_BEQ, OP_SRAI, OP_LUI};
      rds   = '{5'd0, 5'd4, 5'd1};
      rs1s  = '{5'd1, 5'd4, 5'd0};
      rs2s  = '{5'd2, 5'd0, 5'd0};
      imms  = '{32'hFFFF_FFFC, 32'd3, 32'h1234_5000};
      words = '{32'hFE20_8EE3, 32'h4032_5213, 32'h1234_50B7};
      addrs = '{10'd32, 10'd36, 10'd40};
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_op(kinds[i], rds[i], rs1s[i], rs2s[i], imms[i]);
         step();
         checks++; if (bus.instr !== words[i]) begin errors++; $display("[TB] FAIL enc_instr[%0d]: got %h expected %h", i, bus.instr, words[i]); end
         checks++; if (bus.instr_addr !== addrs[i]) begin errors++; $display("[TB] FAIL enc_addr[%0d]: got %0d expected %0d", i, bus.instr_addr, addrs[i]); end
      end
      bus.op_valid = 1'b0;
      step();
   endtask

   task automatic test_errors();
      exp_addr = 10'd44;
      bus.instr_ready = 1'b1;
      drive_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.err_flag !== 1'b1) begin errors++; $display("[TB] FAIL err_range_flag: got %b expected 1", bus.err_flag); end
      checks++; if (bus.err_code !== 2'd2) begin errors++; $display("[TB] FAIL err_range_code: got %0d expected 2", bus.err_code); end
`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
      checks++; if (bus.instr !== 32'h0000_0013) begin errors++; $display("[TB] FAIL err_nop_instr: got %h expected 00000013", bus.instr); end
      checks++; if (bus.instr_addr !== exp_addr) begin errors++; $display("[TB] FAIL err_nop_addr: got %0d expected %0d", bus.instr_addr, exp_addr); end
      exp_addr = exp_addr + 10'd4;
`else
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_range_noword: got %b expected 0", bus.instr_valid); end
`endif
      step();
      drive_op(5'd25, 5'd1, 5'd1, 5'd1, 32'd0);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.err_code !== 2'd2) begin errors++; $display("[TB] FAIL err_sticky_code: got %0d expected 2", bus.err_code); end
`ifdef INSTR_ENCODER_NOP_ON_ERR_EN
      checks++; if (bus.instr_addr !== exp_addr) begin errors++; $display("[TB] FAIL err_nop2_addr: got %0d expected %0d", bus.instr_addr, exp_addr); end
      exp_addr = exp_addr + 10'd4;
`else
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_unknown_noword: got %b expected 0", bus.instr_valid); end
`endif
      step();
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      checks++; if (bus.err_flag !== 1'b0) begin errors++; $display("[TB] FAIL err_clr_flag: got %b expected 0", bus.err_flag); end
      checks++; if (bus.err_code !== 2'd0) begin errors++; $display("[TB] FAIL err_clr_code: got %0d expected 0", bus.err_code); end
      drive_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.instr !== 32'h0050_0093) begin errors++; $display("[TB] FAIL err_after_instr: got %h expected 00500093", bus.instr); end
      checks++; if (bus.instr_addr !== exp_addr) begin errors++; $display("[TB] FAIL err_after_addr: got %0d expected %0d", bus.instr_addr, exp_addr); end
      step();
      drive_op(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.err_code !== 2'd2) begin errors++; $display("[TB] FAIL err_shamt_code: got %0d expected 2", bus.err_code); end
      step();
      bus.err_clr = 1'b1;
      drive_op(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3);
      step();
      bus.op_valid = 1'b0;
      bus.err_clr  = 1'b0;
      checks++; if (bus.err_flag !== 1'b1) begin errors++; $display("[TB] FAIL err_clr_race_flag: got %b expected 1", bus.err_flag); end
      checks++; if (bus.err_code !== 2'd3) begin errors++; $display("[TB] FAIL err_clr_race_code: got %0d expected 3", bus.err_code); end
      step();
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      checks++; if (bus.err_flag !== 1'b0) begin errors++; $display("[TB] FAIL err_final_clr: got %b expected 0", bus.err_flag); end
   endtask

   task automatic test_wrap();
      logic [3:0] addrs [5];
      addrs = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
      w_bus.instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         w_bus.op_valid = 1'b1;
         w_bus.op_kind  = OP_ADDI;
         w_bus.rd       = 5'(i + 1);
         w_bus.rs1      = 5'd0;
         w_bus.rs2      = 5'd0;
         w_bus.imm      = 32'(i);
         step();
         checks++; if (w_bus.instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid[%0d]: got %b expected 1", i, w_bus.instr_valid); end
         checks++; if (w_bus.instr_addr !== addrs[i]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d expected %0d", i, w_bus.instr_addr, addrs[i]); end
      end
      w_bus.op_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_full();
      bus.instr_ready = 1'b0;
      drive_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
      step();
      drive_op(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_ready_pre: got %b expected 0", bus.op_ready); end
      rst = 1'b1;
      step();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstfull_valid: got %b expected 0", bus.instr_valid); end
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstfull_ready: got %b expected 1", bus.op_ready); end
      checks++; if (bus.instr_addr !== 10'd0) begin errors++; $display("[TB] FAIL rstfull_addr: got %0d expected 0", bus.instr_addr); end
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      drive_op(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      step();
      bus.op_valid = 1'b0;
      checks++; if (bus.instr !== 32'h0050_0093) begin errors++; $display("[TB] FAIL rstfull_after_instr: got %h expected 00500093", bus.instr); end
      checks++; if (bus.instr_addr !== 10'd0) begin errors++; $display("[TB] FAIL rstfull_after_addr: got %0d expected 0", bus.instr_addr); end
      step();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_fifo_full();
      test_encodings();
      test_errors();
      test_wrap();
      test_reset_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction encoder, the inverse of the control decoder. Converts a symbolic operation request (op, rd, rs1, rs2, imm) into a 32-bit RV32I machine word.
- Stamps each word with an incrementing instruction-memory byte address.
- Used by the program loader and the verification harness to write instruction memory without a host-side assembler.
- Covers exactly the instruction set the control unit executes.

Parameters:
- ADDR_W, 10, width of instruction-memory byte address
- START_ADDR, 0, address of first emitted word after reset (word aligned)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  request valid
- op_ready  out  1  encoder can accept a request
- op_kind  in  5  operation code (enc_pkg)
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- imm  in  32  signed immediate / byte offset; LUI takes the full upper value
- instr_valid  out  1  output word valid
- instr_ready  in  1  consumer accepts word
- instr  out  32  encoded machine word
- instr_addr  out  ADDR_W  byte address for instr
- err_flag  out  1  sticky: a request was rejected
- err_code  out  2  first error cause: 1 unknown op, 2 immediate out of range, 3 misaligned branch offset
- err_clr  in  1  clears err_flag/err_code

Behaviour:
- Reset: op_ready=1, instr_valid=0, instr=0, instr_addr=START_ADDR, err_flag=0, err_code=0, FIFO empty.
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high. rst mid-operation flushes FIFO contents, drops queued words and restores all reset values.
- Handshake: request accepted when op_valid&&op_ready. Output transfers when instr_valid&&instr_ready. instr, instr_addr and instr_valid hold stable while instr_valid&&!instr_ready.
- Storage: 2-entry output FIFO of {instr, addr}.
  - op_ready = !full || instr_ready; accept and pop in the same cycle when full.
  - Latency from accept to instr_valid: 1 cycle when empty.
  - Empty with simultaneous push and pop: no bypass; the word appears the next cycle.
- Address counter: increments by 4 on every push, not on pop. Wraps modulo 2^ADDR_W. The address is captured at push time.
- Encoding: standard RV32I fields.
  - Opcodes: LUI 0110111; BEQ 1100011; LW 0000011 f3=010; SW 0100011 f3=010.
  - I-ALU 0010011 with f3: ADDI 000, SLLI 001, XORI 100, SRLI 101, SRAI 101 with f7=0100000, ORI 110, ANDI 111.
  - R-type 0110011: ADD, SUB (f7=0100000), SLL, XOR, SRL, OR, AND.
  - Unused fields are zero.
- Range checks (combinational on the request):
  - I-type and LW/SW: imm in [-2048, 2047].
  - Shifts: imm in [0, 31].
  - BEQ: imm in [-4096, 4094] and imm[0]=0.
  - LUI: imm[11:0]=0.
  - op_kind 18..31: unknown op.
- Rejected request: it is still accepted (handshake completes). No FIFO push, address not incremented. err_flag set.
  - err_code records the first cause only; later errors do not overwrite it.
  - err_clr and a new error in the same cycle: the new error wins.

Optional Feature:
- Macro: INSTR_ENCODER_NOP_ON_ERR_EN.
- Defined: a rejected request pushes NOP 0x00000013 at the next address and the counter advances, keeping the program layout aligned. err_flag/err_code still update.
- Undefined: the rejected request is dropped as described above.

Decomposition:
- Package enc_pkg holds:
  - op_kind constants: LUI=0, BEQ=1, LW=2, SW=3, ADDI=4, SLLI=5, XORI=6, SRLI=7, SRAI=8, ORI=9, ANDI=10, ADD=11, SUB=12, SLL=13, XOR=14, SRL=15, OR=16, AND=17.
  - 7-bit opcode constants shared with the control unit.
  - err_code constants.
  - NOP constant.
- Sub-module enc_fifo2: 2-entry synchronous FIFO with valid/ready on both sides. The encoder core itself is combinational, feeding the FIFO.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 imm=5 -> instr=0x00500093, instr_addr=0, one cycle after accept.
- Back-to-back requests with instr_ready=1:
  - ADD 3,1,2 -> 0x002081B3 @4
  - SUB 3,1,2 -> 0x402081B3 @8
  - LW 5,8(2) -> 0x00812283 @12
  - SW 5,12(2) -> 0x00512623 @16
- instr_ready=0: two requests fill the FIFO and op_ready drops. The third is held until a pop; order and addresses are preserved.
- Further encodings:
  - BEQ 1,2,-4 -> 0xFE208EE3
  - SRAI 4,4,3 -> 0x40325213
  - LUI 1,0x12345000 -> 0x123450B7
- Error paths:
  - ADDI imm=4096 -> no word, err_flag=1, err_code=2.
  - Then op_kind=25 -> err_code stays 2.
  - err_clr -> 0.
  - With the macro defined: 0x00000013 emitted and the address advances.
- Address wrap: with ADDR_W=4, after 4 words addr wraps to 0.
- rst asserted while the FIFO is full: instr_valid=0 next cycle.
